// File: rtl/param_frame_sync.sv
// Triggered frame capture: buffers an ADC stream, detects a block whose mean |x| exceeds
// THRESH and replays a decimated frame starting PRE_LEN samples before that block.
// aresetn is expected to be released synchronously to aclk by the surrounding reset logic.
module param_frame_sync #(
    parameter int ADC_W     = 14,
    parameter int ADDR_W    = 10,
    parameter int PRE_LEN   = 64,
    parameter int FRAME_LEN = 512,
    parameter int DS        = 4,
    parameter int WIN_LOG   = 4,
    parameter int THRESH    = 1000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    input  logic        arm,
    input  logic        one_shot,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] frame_cnt
);

    localparam int D      = 1 << ADDR_W;
    localparam int W      = 1 << WIN_LOG;
    localparam int ACC_W  = ADC_W + WIN_LOG;
    localparam int WARM   = PRE_LEN + W;
    localparam int WARM_W = $clog2(WARM);
    localparam int BEAT_W = $clog2(FRAME_LEN + 1);
    localparam int LEAD_W = ADDR_W + 2;
    localparam logic [31:0] THRESH_U = 32'(THRESH);

    typedef enum logic [1:0] {IDLE, SEARCH, WAIT, OUTPUT} state_t;

    state_t state, state_d;

    logic [ADDR_W-1:0]  wp, rp;
    logic [ACC_W-1:0]   acc;
    logic [WIN_LOG-1:0] blk_cnt;
    logic [WARM_W-1:0]  warm_cnt;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [LEAD_W-1:0]  lead;
    logic [ADC_W-1:0]   mem [D];
    logic [ADC_W-1:0]   rd_data;

    logic [ADC_W-1:0]  x_raw;
    logic [ADC_W-1:0]  x_abs;
    logic [ACC_W-1:0]  acc_sum;
    logic [ACC_W-1:0]  mean;
    logic [ADDR_W-1:0] fill;
    logic              accept, block_end, warm_ok, trigger;
    logic              hs, last_hs, can_load, lead_inc, entering_search;
    logic              unused_upper;

    assign s_axis_tready = aresetn;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign x_raw         = s_axis_tdata[ADC_W-1:0];
    assign unused_upper  = ^s_axis_tdata[31:ADC_W];

    // Two's-complement negate of the most negative code yields 2^(ADC_W-1) read as unsigned.
    assign x_abs     = x_raw[ADC_W-1] ? (~x_raw + 1'b1) : x_raw;
    assign acc_sum   = acc + ACC_W'(x_abs);
    assign mean      = acc_sum >> WIN_LOG;
    assign block_end = accept && (&blk_cnt);
    assign warm_ok   = (warm_cnt >= WARM_W'(WARM - 1));
    assign trigger   = (state == SEARCH) && block_end && (32'(mean) > THRESH_U) && warm_ok;

    assign hs       = m_axis_tvalid && m_axis_tready;
    assign last_hs  = hs && m_axis_tlast;
    // lead counts written samples at or beyond rp; it may dip negative after a DS step.
    assign can_load = (state == OUTPUT) && !m_axis_tvalid && !lead[LEAD_W-1] && (lead != '0);
    assign lead_inc = accept && (lead[LEAD_W-1] || (lead < LEAD_W'(D)));
    assign fill     = wp - rp;

    assign entering_search = ((state == IDLE) && arm) || (last_hs && !one_shot);

    assign busy         = (state != IDLE);
    assign m_axis_tdata = m_axis_tvalid ? {{(32-ADC_W){rd_data[ADC_W-1]}}, rd_data} : 32'd0;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state;
        case (state)
            IDLE:    if (arm) state_d = SEARCH;
            SEARCH:  if (trigger) state_d = WAIT;
            WAIT:    if (rp != wp) state_d = OUTPUT;
            OUTPUT:  if (last_hs) state_d = one_shot ? IDLE : SEARCH;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // NOTE: the sample buffer has no reset; its contents are don't-care until written.
    always_ff @(posedge aclk) begin
        if (accept) begin
            mem[wp] <= x_raw;
        end
        if (can_load) begin
            rd_data <= mem[rp];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wp            <= '0;
            rp            <= '0;
            acc           <= '0;
            blk_cnt       <= '0;
            warm_cnt      <= '0;
            beat_cnt      <= '0;
            lead          <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            overflow      <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            if (accept) begin
                wp      <= wp + 1'b1;
                blk_cnt <= blk_cnt + 1'b1;
                acc     <= block_end ? '0 : acc_sum;
            end

            if (entering_search) begin
                warm_cnt <= '0;
            end else if ((state == SEARCH) && accept && !warm_ok) begin
                warm_cnt <= warm_cnt + 1'b1;
            end

            if ((state == IDLE) && arm) begin
                overflow <= 1'b0;
            end else if (accept && ((state == WAIT) || (state == OUTPUT)) && (fill == '1)) begin
                overflow <= 1'b1;
            end

            if (trigger) begin
                rp       <= wp - ADDR_W'(W - 1 + PRE_LEN);
                lead     <= LEAD_W'(WARM);
                beat_cnt <= '0;
            end else begin
                lead <= lead + (lead_inc ? LEAD_W'(1) : '0) - (hs ? LEAD_W'(DS) : '0);
                if (hs) begin
                    rp <= rp + ADDR_W'(DS);
                end
            end

            if (can_load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (beat_cnt == BEAT_W'(FRAME_LEN - 1));
            end else if (hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
                beat_cnt      <= m_axis_tlast ? '0 : beat_cnt + 1'b1;
            end

            if (last_hs) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_param_frame_sync.sv
// Scoreboard bench for param_frame_sync: stimulus pushes expected beats into a queue,
// an independent monitor pops and compares them on every output handshake.
`timescale 1ns/1ps
module tb_param_frame_sync;

    localparam int ADC_W = 14, ADDR_W = 6, PRE_LEN = 4, FRAME_LEN = 8;
    localparam int DS = 2, WIN_LOG = 2, THRESH = 100;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tlast;
    logic        arm = 1'b0;
    logic        one_shot = 1'b1;
    logic        busy;
    logic        overflow;
    logic [15:0] frame_cnt;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_pass = 0;
    int    rdy_mode = 0;   // 0: always ready, 1: toggle 1,0, 2: never ready
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    param_frame_sync #(
        .ADC_W(ADC_W), .ADDR_W(ADDR_W), .PRE_LEN(PRE_LEN), .FRAME_LEN(FRAME_LEN),
        .DS(DS), .WIN_LOG(WIN_LOG), .THRESH(THRESH)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .arm(arm), .one_shot(one_shot), .busy(busy), .overflow(overflow), .frame_cnt(frame_cnt)
    );

    initial forever #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    initial forever begin
        @(posedge aclk);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
        endcase
    end

    // Monitor: hold-stability during stalls, scoreboard compare on each handshake.
    initial forever begin
        @(negedge aclk);
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_data", m_axis_tdata, prev_data);
                check("hold_last", 32'(m_axis_tlast), 32'(prev_last));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", m_axis_tdata, 32'hDEAD_BEEF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_last", 32'(m_axis_tlast), 32'(e.last));
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic do_reset();
        aresetn = 1'b0;
        arm = 1'b0;
        s_axis_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(posedge aclk);
        #1;
        arm = 1'b0;
    endtask

    task automatic send(input int v);
        s_axis_tdata = 32'(v);
        s_axis_tvalid = 1'b1;
        @(posedge aclk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int limit);
        for (int i = 0; i < limit && frame_cnt != 16'(target); i++) begin
            @(posedge aclk);
            #1;
        end
        check("frame_cnt", 32'(frame_cnt), 32'(target));
    endtask

    task automatic expect_frame(input int v0, input int v1, input int v2, input int v3,
                                input int v4, input int v5, input int v6, input int v7);
        int v[8];
        v = '{v0, v1, v2, v3, v4, v5, v6, v7};
        for (int i = 0; i < 8; i++) exp_q.push_back('{data: 32'(v[i]), last: (i == 7)});
    endtask

    function automatic int ramp(input int n);
        return (n < 24) ? n : 1000 + n;
    endfunction

    function automatic int bursts(input int n);
        if (n < 8) return n;
        if (n < 12) return 500 + n;
        if (n >= 52 && n < 56) return 700 + n;
        return 0;
    endfunction

    initial begin
        logic busy_low;

        // Reset values, then ready after release
        #2;
        check("rst_tvalid", 32'(m_axis_tvalid), 0);
        check("rst_tlast", 32'(m_axis_tlast), 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        do_reset();
        check("tready_after_rst", 32'(s_axis_tready), 1);

        // Single frame, always ready
        rdy_mode = 0;
        one_shot = 1'b1;
        expect_frame(20, 22, 1024, 1026, 1028, 1030, 1032, 1034);
        pulse_arm();
        check("busy_after_arm", 32'(busy), 1);
        for (int n = 0; n < 40; n++) send(ramp(n));
        wait_frames(1, 100);
        check("busy_one_shot", 32'(busy), 0);
        check("queue_drained_1", 32'(exp_q.size()), 0);

        // Same frame with back-pressure toggling
        do_reset();
        rdy_mode = 1;
        expect_frame(20, 22, 1024, 1026, 1028, 1030, 1032, 1034);
        pulse_arm();
        for (int n = 0; n < 40; n++) send(ramp(n));
        wait_frames(1, 200);
        check("busy_stall_frame", 32'(busy), 0);
        check("queue_drained_2", 32'(exp_q.size()), 0);

        // Continuous mode: two bursts separated by 40 zeros
        do_reset();
        rdy_mode = 0;
        one_shot = 1'b0;
        expect_frame(4, 6, 508, 510, 0, 0, 0, 0);
        expect_frame(0, 0, 752, 754, 0, 0, 0, 0);
        pulse_arm();
        busy_low = 1'b0;
        for (int n = 0; n < 76; n++) begin
            send(bursts(n));
            if (!busy) busy_low = 1'b1;
        end
        wait_frames(2, 100);
        check("busy_never_low", 32'(busy_low), 0);
        check("busy_continuous", 32'(busy), 1);
        check("queue_drained_3", 32'(exp_q.size()), 0);

        // Overflow: sink stalled while the writer laps the read pointer
        do_reset();
        rdy_mode = 2;
        one_shot = 1'b1;
        expect_frame(20, 1086, 1088, 1090, 1092, 1094, 1096, 1098);
        pulse_arm();
        for (int n = 0; n < 100; n++) send(ramp(n));
        check("overflow_set", 32'(overflow), 1);
        check("busy_during_stall", 32'(busy), 1);
        rdy_mode = 0;
        wait_frames(1, 100);
        check("overflow_sticky", 32'(overflow), 1);
        check("busy_after_ovf_frame", 32'(busy), 0);
        check("queue_drained_4", 32'(exp_q.size()), 0);
        pulse_arm();
        check("overflow_cleared", 32'(overflow), 0);

        // Most-negative block triggers; asynchronous reset mid-frame
        do_reset();
        rdy_mode = 2;
        pulse_arm();
        for (int n = 0; n < 8; n++) send(n + 1);
        for (int n = 0; n < 4; n++) send(-8192);
        for (int n = 0; n < 4; n++) send(0);
        check("neg_trigger_valid", 32'(m_axis_tvalid), 1);
        check("neg_trigger_data", m_axis_tdata, 5);
        check("neg_trigger_busy", 32'(busy), 1);
        #2;
        aresetn = 1'b0;
        #1;
        check("async_rst_tvalid", 32'(m_axis_tvalid), 0);
        check("async_rst_tdata", m_axis_tdata, 0);
        check("async_rst_tlast", 32'(m_axis_tlast), 0);
        check("async_rst_busy", 32'(busy), 0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        repeat (4) @(posedge aclk);
        #1;
        check("post_rst_idle", 32'(busy), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
